// File: rtl/vram_scanout.sv
// Frame scanout from VRAM: credit-limited word reads into a small FIFO, then
// unpacks each 64-bit word into eight byte pixels on a valid/ready stream.
module vram_scanout #(
   parameter int ADDR_WIDTH  = 14,
   parameter int FRAME_WORDS = 12288,
   parameter int RD_LATENCY  = 3,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  vram_en,
   output logic [ADDR_WIDTH-1:0] vram_addr,
   input  logic [63:0]           vram_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [7:0]            m_data,
   output logic                  m_last
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
   logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
   logic [63:0]           mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [63:0]           word_q, word_d;
   logic [2:0]            idx_q, idx_d;
   logic                  wvld_q, wvld_d;
   logic                  lastw_q, lastw_d;

   logic [SW-1:0]         inflight;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  hs;

   // Outstanding requests plus stored words must never exceed the FIFO size,
   // so every returning word has a guaranteed slot.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + SW'(vld_sr_q[i]);
      end
   end

   assign issue = (state_q == S_RUN) &&
                  ((inflight + SW'(count_q)) < SW'(FIFO_DEPTH));
   assign push  = vld_sr_q[RD_LATENCY-1];
   assign hs    = wvld_q && m_ready;
   assign pop   = (count_q != '0) && (!wvld_q || (hs && (idx_q == 3'd7)));

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign vram_en   = issue;
   assign vram_addr = addr_q;
   assign m_valid   = wvld_q;
   assign m_data    = word_q[{idx_q, 3'b000} +: 8];
   assign m_last    = lastw_q && (idx_q == 3'd7) && wvld_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pop_cnt_d = pop_cnt_q;
      if (pop) begin
         pop_cnt_d = pop_cnt_q + ADDR_WIDTH'(1);
      end
      unique case (state_q)
         S_IDLE: begin
            addr_d    = '0;
            pop_cnt_d = '0;
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (issue) begin
               if (addr_q == LAST_ADDR) begin
                  state_d = S_DRAIN;
               end else begin
                  addr_d = addr_q + ADDR_WIDTH'(1);
               end
            end
         end
         S_DRAIN: begin
            if (hs && m_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      vld_sr_d[0] = issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
         vld_sr_d[i] = vld_sr_q[i-1];
      end
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   // Unpacker reloads on the same cycle byte 7 is accepted to keep 1 pixel/clk.
   always_comb begin
      word_d  = word_q;
      idx_d   = idx_q;
      wvld_d  = wvld_q;
      lastw_d = lastw_q;
      if (pop) begin
         word_d  = mem_q[rd_ptr_q];
         idx_d   = 3'd0;
         wvld_d  = 1'b1;
         lastw_d = (pop_cnt_q == LAST_ADDR);
      end else if (hs) begin
         idx_d = idx_q + 3'd1;
         if (idx_q == 3'd7) begin
            wvld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         pop_cnt_q <= '0;
         vld_sr_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         word_q    <= '0;
         idx_q     <= '0;
         wvld_q    <= 1'b0;
         lastw_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         pop_cnt_q <= pop_cnt_d;
         vld_sr_q  <= vld_sr_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         word_q    <= word_d;
         idx_q     <= idx_d;
         wvld_q    <= wvld_d;
         lastw_q   <= lastw_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= vram_rdata;
      end
   end

endmodule
